// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory loader.
package mips_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;
   localparam int HDR_W  = 16;

   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      DATA,
      CHK,
      DONE,
      ERR
   } ldr_state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs accepted payload bytes into big-endian 32-bit words.
// word is valid alongside word_done, the strobe for the 4th byte of a word.
module imem_word_assembler
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_vld,
   output logic [WORD_W-1:0] word,
   output logic              word_done
);

   // Only the three earlier bytes are held; the 4th is taken straight from the input.
   logic [WORD_W-BYTE_W-1:0] shreg;
   logic [1:0]               byte_cnt;

   assign word      = {shreg, byte_in};
   assign word_done = byte_vld && (byte_cnt == 2'd3);

   // Shift in each payload byte and count position within the word.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shreg    <= '0;
         byte_cnt <= '0;
      end else if (byte_vld) begin
         shreg    <= {shreg[WORD_W-2*BYTE_W-1:0], byte_in};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a framed byte stream (count header,
// big-endian payload words, XOR checksum), writes words to sequential
// addresses and releases the CPU once the checksum matches.
// Optional inter-byte timeout: define IMEM_LOADER_TIMEOUT_EN.
module imem_loader
   import mips_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int MAX_WORDS   = 256,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   ldr_state_t        state, state_nx;
   logic              accept;
   logic [HDR_W-1:0]  n_words;
   logic [HDR_W-1:0]  hdr_n;
   logic [BYTE_W-1:0] chk_acc;
   logic [ADDR_W-1:0] word_idx;
   logic              last_word;
   logic              timeout_hit;
   logic              asm_vld;
   logic [WORD_W-1:0] asm_word;
   logic              asm_done;

   assign accept    = in_valid && in_ready;
   assign hdr_n     = {n_words[HDR_W-1:BYTE_W], in_data};
   assign last_word = (32'(word_idx) + 32'd1) == 32'(n_words);
   assign asm_vld   = accept && (state == DATA);

   imem_word_assembler u_asm (
      .clk       (clk),
      .reset     (reset),
      .byte_in   (in_data),
      .byte_vld  (asm_vld),
      .word      (asm_word),
      .word_done (asm_done)
   );

`ifdef IMEM_LOADER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt;
   logic            to_active;

   // HDR_HI is excluded so the loader can wait forever for a frame to start.
   assign to_active   = (state == HDR_LO) || (state == DATA) || (state == CHK);
   assign timeout_hit = to_active && !accept && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

   // Count idle cycles between bytes; any transfer restarts the count.
   always_ff @(posedge clk) begin
      if (!reset || !to_active || accept) to_cnt <= '0;
      else                                to_cnt <= to_cnt + TO_W'(1);
   end
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
   assign timeout_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= HDR_HI;
      else        state <= state_nx;
   end

   // Next-state logic; every advance needs an accepted byte.
   always_comb begin
      state_nx = state;
      unique case (state)
         HDR_HI: if (accept) state_nx = HDR_LO;
         HDR_LO: if (accept) begin
            if (int'(hdr_n) > MAX_WORDS) state_nx = ERR;
            else if (hdr_n == '0)       state_nx = CHK;
            else                        state_nx = DATA;
         end
         DATA:   if (asm_done && last_word) state_nx = CHK;
         CHK:    if (accept) state_nx = (in_data == chk_acc) ? DONE : ERR;
         default: state_nx = state;
      endcase
      if (timeout_hit) state_nx = ERR;
   end

   // Status outputs registered from next state so they change with the state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_ready <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         cpu_hold <= 1'b1;
      end else begin
         in_ready <= (state_nx == HDR_HI) || (state_nx == HDR_LO) ||
                     (state_nx == DATA)   || (state_nx == CHK);
         done     <= (state_nx == DONE);
         error    <= (state_nx == ERR);
         cpu_hold <= (state_nx != DONE);
      end
   end

   // Capture the header count and fold every pre-checksum byte into the XOR.
   always_ff @(posedge clk) begin
      if (!reset) begin
         n_words <= '0;
         chk_acc <= '0;
      end else if (accept) begin
         if (state == HDR_HI) n_words[HDR_W-1:BYTE_W] <= in_data;
         if (state == HDR_LO) n_words[BYTE_W-1:0]     <= in_data;
         if ((state == HDR_HI) || (state == HDR_LO) || (state == DATA))
            chk_acc <= chk_acc ^ in_data;
      end
   end

   // Issue a one-cycle write per completed word at sequential addresses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         word_idx <= '0;
      end else begin
         wr_en <= asm_done;
         if (asm_done) begin
            wr_addr <= word_idx;
            wr_data <= asm_word;
            // The last word leaves the index alone so it never wraps.
            if (!last_word) word_idx <= word_idx + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a
// monitor pops and compares on each wr_en; status checked after each frame.
module tb_imem_loader;

   localparam int ADDR_W      = 8;
   localparam int MAX_WORDS   = 256;
   localparam int TIMEOUT_CYC = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_hold;
   logic        done;
   logic        error;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   bit  stall_en = 0;

   imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (reset === 1'b1 && wr_en === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: addr %h data %h, expected no write", wr_addr, wr_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (wr_addr !== e.addr || wr_data !== e.data) begin
               n_fail++;
               $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                        wr_addr, wr_data, e.addr, e.data);
            end
         end
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one byte and return 1ns after the edge that transfers it.
   task automatic send(input logic [7:0] b);
      int n;
      if (stall_en) idle(int'($urandom_range(0, 2)));
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0, expected 1 for byte %h", b);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic push_wr(input int a, input logic [31:0] d);
      wr_t e;
      e.addr = ADDR_W'(a);
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] gen_word(input int kind, input int i);
      logic [7:0] b;
      b = 8'(i);
      if (kind == 0) return (i == 0) ? 32'h2008_0005 : 32'h8C01_0004;
      return {b, ~b, 8'hA5, b ^ 8'h3C};
   endfunction

   // Full frame: header, N words, checksum (xor-ed with chk_flip to corrupt it).
   task automatic send_frame(input int n, input int kind, input logic [7:0] chk_flip);
      logic [7:0]  acc;
      logic [15:0] nn;
      logic [31:0] w;
      nn  = 16'(n);
      acc = nn[15:8] ^ nn[7:0];
      send(nn[15:8]);
      send(nn[7:0]);
      for (int i = 0; i < n; i++) begin
         w = gen_word(kind, i);
         acc = acc ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
         send(w[31:24]);
         send(w[23:16]);
         send(w[15:8]);
         push_wr(i, w);
         send(w[7:0]);
      end
      send(acc ^ chk_flip);
   endtask

   task automatic chk_status(input string tag, input logic d, input logic e, input logic h, input logic r);
      chk({tag, "_done"},     32'(done),     32'(d));
      chk({tag, "_error"},    32'(error),    32'(e));
      chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(r));
   endtask

   task automatic chk_drained(input string tag);
      @(negedge clk);
      #1;
      chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_status("reset", 1'b0, 1'b0, 1'b1, 1'b0);
      chk("reset_wr_en",   32'(wr_en),   32'd0);
      chk("reset_wr_addr", 32'(wr_addr), 32'd0);
      chk("reset_wr_data", wr_data,      32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_reset", 32'(in_ready), 32'd1);

      // Single word, hand-computed checksum 0x2C.
      send(8'h00); send(8'h01);
      send(8'h20); send(8'h08); send(8'h00);
      push_wr(0, 32'h2008_0005);
      send(8'h05);
      chk("single_wr_pulse", 32'(wr_en), 32'd1);
      send(8'h2C);
      chk("single_wr_one_cycle", 32'(wr_en), 32'd0);
      chk_status("single", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_drained("single");

      // Bad checksum 0x2D: word still written, frame rejected.
      do_reset();
      send(8'h00); send(8'h01);
      send(8'h20); send(8'h08); send(8'h00);
      push_wr(0, 32'h2008_0005);
      send(8'h05);
      send(8'h2D);
      chk_status("badchk", 1'b0, 1'b1, 1'b1, 1'b0);
      chk_drained("badchk");

      // Oversize header N=257: error right after N_lo, no writes.
      do_reset();
      send(8'h01); send(8'h01);
      chk_status("oversize", 1'b0, 1'b1, 1'b1, 1'b0);
      idle(5);
      chk_drained("oversize");

      // N=2 without stalls, then the same frame with random stalls.
      do_reset();
      send_frame(2, 0, 8'h00);
      chk_status("n2", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_drained("n2");
      do_reset();
      stall_en = 1;
      send_frame(2, 0, 8'h00);
      stall_en = 0;
      chk_status("n2_stall", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_drained("n2_stall");

      // N=0: header straight to checksum.
      do_reset();
      send(8'h00); send(8'h00); send(8'h00);
      chk_status("n0", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_drained("n0");

      // Reset mid-frame after two payload bytes, then a clean N=1 frame (chk 0x45).
      do_reset();
      send(8'h00); send(8'h01); send(8'hAA); send(8'hBB);
      do_reset();
      chk_status("midrst", 1'b0, 1'b0, 1'b1, 1'b1);
      send(8'h00); send(8'h01);
      send(8'h11); send(8'h22); send(8'h33);
      push_wr(0, 32'h1122_3344);
      send(8'h44);
      send(8'h45);
      chk_status("midrst_frame", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_drained("midrst");

      // Largest frame, N=MAX_WORDS: last write lands at MAX_WORDS-1.
      do_reset();
      send_frame(MAX_WORDS, 1, 8'h00);
      chk("max_last_addr", 32'(wr_addr), 32'(MAX_WORDS - 1));
      chk_status("max", 1'b1, 1'b0, 1'b0, 1'b0);
      chk_drained("max");

      // Stream stops after N_lo.
      do_reset();
      send(8'h00); send(8'h01);
`ifdef IMEM_LOADER_TIMEOUT_EN
      idle(TIMEOUT_CYC - 1);
      chk("timeout_not_yet", 32'(error), 32'd0);
      idle(1);
      chk_status("timeout", 1'b0, 1'b1, 1'b1, 1'b0);
`else
      idle(40);
      chk_status("no_timeout", 1'b0, 1'b0, 1'b1, 1'b1);
`endif
      chk_drained("timeout");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: the CPU only reads instruction memory, and this block fills it before the CPU runs.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to sequential instruction-memory word addresses.
- Holds the CPU in reset until a frame has loaded and its checksum has verified.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- MAX_WORDS, 256, largest accepted word count; must be <= 2**ADDR_W.
- TIMEOUT_CYC, 1024, inter-byte timeout in cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at a clk edge.
- wr_en  output  1  one-cycle instruction-memory write strobe.
- wr_addr  output  ADDR_W  word address of the write.
- wr_data  output  32  word to write.
- cpu_hold  output  1  active-high reset request to the CPU.
- done  output  1  frame loaded and checksum matched; sticky.
- error  output  1  frame rejected; sticky.

Behaviour:
- Reset: clk and reset as named above; reset is synchronous, active-low.
  - While reset==0 at a clk edge: state=HDR_HI; wr_en=0, wr_addr=0, wr_data=0; cpu_hold=1, done=0, error=0, in_ready=0.
  - Word/byte counters and the checksum accumulator clear.
  - Memory contents are not cleared. Reset mid-frame discards the partial word; no further write issues.
- Frame format, all bytes in order:
  - N_hi, N_lo: 16-bit word count N.
  - N*4 payload bytes, most-significant byte of each word first.
  - CHK: XOR of every preceding byte in the frame, including the header.
- in_ready is 1 in HDR_HI, HDR_LO, DATA and CHK; 0 in DONE and ERR. in_ready rises the cycle after reset deasserts.
- FSM transitions (each advance requires an accepted byte):
  - HDR_HI -> HDR_LO.
  - HDR_LO: N > MAX_WORDS -> ERR; N == 0 -> CHK; otherwise -> DATA.
  - DATA: on accepting the 4th byte of the last word -> CHK.
  - CHK: byte == accumulator -> DONE, else -> ERR.
  - DONE and ERR hold until reset.
- Word assembly:
  - Shift register, shift left 8 per accepted byte.
  - On the 4th byte, register wr_data = assembled word and wr_addr = word index, and pulse wr_en=1 for exactly one cycle, the cycle after the 4th byte is accepted.
  - Word index starts at 0 and increments by 1 per word. It reaches at most MAX_WORDS-1, so it never wraps.
- Back-to-back bytes, one per cycle, are accepted with no bubbles. in_valid low stalls the FSM with no state change.
- cpu_hold:
  - Drops to 0 the same cycle done rises, which is the cycle after CHK is accepted.
  - Remains 1 in ERR.
- done and error are mutually exclusive.

Optional Feature:
- Macro: IMEM_LOADER_TIMEOUT_EN.
- Defined:
  - A counter is active in HDR_LO, DATA and CHK.
  - It clears on every accepted byte and increments on cycles with no transfer.
  - When it reaches TIMEOUT_CYC, the next state is ERR.
  - HDR_HI never times out, so the loader can wait indefinitely for a frame to start.
- Not defined: no counter is built and the FSM waits indefinitely in every state. TIMEOUT_CYC is ignored.

Decomposition:
- Shared package mips_pkg holds:
  - the loader state enum (HDR_HI, HDR_LO, DATA, CHK, DONE, ERR);
  - BYTE_W=8 and WORD_W=32;
  - the frame header width constant (16).
- One natural sub-module: imem_word_assembler.
  - Contents: byte shift register, 2-bit byte counter, word-complete strobe.
  - The FSM, checksum and address counter stay in the top level.

Test Plan:
- Single word: bytes 00,01,20,08,00,05,2C with in_valid held high.
  - One wr_en pulse, wr_addr=0, wr_data=0x20080005, the cycle after byte 0x05.
  - done=1 and cpu_hold=0 the cycle after 0x2C.
- Bad checksum: same frame but CHK=0x2D.
  - Word written to addr 0; error=1, done=0, cpu_hold=1, in_ready=0.
- Oversize: header 0x01,0x01 (N=257) with MAX_WORDS=256.
  - ERR after the 2nd byte; no wr_en ever.
- Stalls: N=2 frame with in_valid toggled randomly.
  - Writes at addr 0 then 1, data unchanged versus the no-stall run, done=1.
- Reset mid-frame: reset low after the 2nd payload byte, then a full valid N=1 frame.
  - No write from the aborted frame; the new frame writes addr 0 and sets done.
- With IMEM_LOADER_TIMEOUT_EN, TIMEOUT_CYC=16: stop after N_lo.
  - error=1 exactly 16 idle cycles later.
  - Without the macro, the same stimulus leaves error=0 indefinitely.
